// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM states, grant IDs,
// access size codes and the latency-counter load helper.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for the largest supported latency of 15.
    localparam int LAT_W = 4;

    function automatic logic [LAT_W-1:0] lat_load(input int mem_lat);
        return LAT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_mem_lane_align.sv
// Combinational lane alignment for data accesses: byte enables, replicated
// store data and misalignment detection from size and the low address bits.
module mem_lane_align
    import unified_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            // SZ_WORD and the reserved code 2'b11 both behave as a word
            default: begin
                be_o       = 4'b1111;
                wdata_o    = wdata_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between fetch and data ports.
// Optional wait-cycle performance counters are enabled by MEM_ARB_PERF_CNT_EN.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [1:0]        d_size_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_ready_o,
    output logic              d_misalign_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  perf_if_wait_o,
    output logic [CNT_W-1:0]  perf_d_wait_o
);

    state_e              state_q, state_d;
    grant_e              last_grant_q;
    logic                we_q, misalign_q;
    logic [3:0]          be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q, if_rdata_q, d_rdata_q;
    logic [LAT_W-1:0]    lat_q;

    logic [3:0]  d_be_w;
    logic [31:0] d_wdata_w;
    logic        d_misalign_w;
    logic        any_req, pick_d, grant_now, lat_done;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0], d_addr_i[31:ADDR_W+2]};

    mem_lane_align u_align (
        .size_i     (d_size_i),
        .addr_lo_i  (d_addr_i[1:0]),
        .wdata_i    (d_wdata_i),
        .be_o       (d_be_w),
        .wdata_o    (d_wdata_w),
        .misalign_o (d_misalign_w)
    );

    // On a tie the port that did not win last time is served.
    assign any_req   = if_req_i | d_req_i;
    assign pick_d    = d_req_i & (~if_req_i | (last_grant_q == GNT_IF));
    assign grant_now = (state_q == ST_IDLE) & any_req;
    assign lat_done  = (lat_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = (pick_d && d_misalign_w) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (lat_done) state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= GNT_IF;
            we_q         <= 1'b0;
            misalign_q   <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if (grant_now) begin
                last_grant_q <= pick_d ? GNT_D : GNT_IF;
                we_q         <= pick_d & d_we_i;
                be_q         <= pick_d ? d_be_w : 4'b1111;
                addr_q       <= pick_d ? d_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
                wdata_q      <= pick_d ? d_wdata_w : '0;
                misalign_q   <= pick_d & d_misalign_w;
                if (pick_d && d_misalign_w) d_rdata_q <= '0;
            end
            if (state_q == ST_ISSUE)     lat_q <= lat_load(MEM_LAT);
            else if (state_q == ST_WAIT) lat_q <= lat_q - LAT_W'(1);
            if (state_q == ST_WAIT && lat_done) begin
                if (last_grant_q == GNT_D) d_rdata_q  <= mem_rdata_i;
                else                       if_rdata_q <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        if_ready_o   = 1'b0;
        d_ready_o    = 1'b0;
        d_misalign_o = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = we_q;
                mem_be_o    = be_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            ST_RESP: begin
                if_ready_o   = (last_grant_q == GNT_IF);
                d_ready_o    = (last_grant_q == GNT_D);
                d_misalign_o = (last_grant_q == GNT_D) & misalign_q;
            end
            default: ;
        endcase
    end

    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] perf_if_q, perf_d_q;

    // Saturating counts of cycles spent requesting without completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            if (if_req_i && !if_ready_o && perf_if_q != '1) perf_if_q <= perf_if_q + CNT_W'(1);
            if (d_req_i && !d_ready_o && perf_d_q != '1)    perf_d_q  <= perf_d_q + CNT_W'(1);
        end
    end

    assign perf_if_wait_o = perf_if_q;
    assign perf_d_wait_o  = perf_d_q;
`else
    assign perf_if_wait_o = '0;
    assign perf_d_wait_o  = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed sequences, a vector table
// and a randomized phase against a transaction-level model with a shadow memory.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef MEM_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst3_n;

    logic          if_req, if_ready, d_req, d_we, d_ready, d_misalign;
    logic [31:0]   if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]    d_size;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [CW-1:0] perf_if, perf_d;

    logic          if3_req, if3_ready, d3_req, d3_we, d3_ready, d3_misalign;
    logic [31:0]   if3_addr, if3_rdata, d3_addr, d3_wdata, d3_rdata;
    logic [1:0]    d3_size;
    logic          mem3_en, mem3_we;
    logic [3:0]    mem3_be;
    logic [AW-1:0] mem3_addr;
    logic [31:0]   mem3_wdata, mem3_rdata;
    logic [CW-1:0] perf3_if, perf3_d;

    unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT1), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ready_o(d_ready), .d_misalign_o(d_misalign),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .perf_if_wait_o(perf_if), .perf_d_wait_o(perf_d)
    );

    unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT3), .CNT_W(CW)) dut3 (
        .clk_i(clk), .rst_ni(rst3_n),
        .if_req_i(if3_req), .if_addr_i(if3_addr), .if_rdata_o(if3_rdata), .if_ready_o(if3_ready),
        .d_req_i(d3_req), .d_we_i(d3_we), .d_size_i(d3_size), .d_addr_i(d3_addr), .d_wdata_i(d3_wdata),
        .d_rdata_o(d3_rdata), .d_ready_o(d3_ready), .d_misalign_o(d3_misalign),
        .mem_en_o(mem3_en), .mem_we_o(mem3_we), .mem_be_o(mem3_be), .mem_addr_o(mem3_addr),
        .mem_wdata_o(mem3_wdata), .mem_rdata_i(mem3_rdata),
        .perf_if_wait_o(perf3_if), .perf_d_wait_o(perf3_d)
    );

    // Memory macro models: byte-enabled storage with one-cycle read latency for dut,
    // and an address-derived read pattern with three-cycle latency for dut3.
    logic [31:0] env_mem [256];
    logic [31:0] pipe1;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        pipe1 <= mem_en ? env_mem[mem_addr] : 32'hDEADBEEF;
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    assign mem_rdata = pipe1;

    always @(posedge clk) begin
        p3[0] <= mem3_en ? {24'hA5A5A5, mem3_addr} : 32'hDEADBEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem3_rdata = p3[2];

    logic [31:0] shadow [256];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'h5A, ~b, 8'(i * 3)};
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return lo[0];
        return lo != 2'b00;
    endfunction

    function automatic void shadow_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n, w, off;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        w   = int'(a[9:2]);
        off = int'(a[1:0]);
        for (int i = 0; i < n; i++) shadow[w][8*(off+i) +: 8] = wd[8*i +: 8];
    endfunction

    // One isolated transaction on dut, issued at the current sample point (cycle 0).
    task automatic run_one(input bit is_d, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int en_cyc, output int rdy_cyc, output int en_cnt,
                           output logic [3:0] be, output logic [31:0] mwd, output logic mwe,
                           output logic [AW-1:0] maddr, output logic mis, output logic [31:0] rdata);
        en_cyc = -1; rdy_cyc = -1; en_cnt = 0; be = '0; mwd = '0; mwe = 1'b0;
        maddr = '0; mis = 1'b0; rdata = '0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = k;
                be = mem_be; mwd = mem_wdata; mwe = mem_we; maddr = mem_addr;
            end
            if (is_d ? d_ready : if_ready) begin
                rdy_cyc = k;
                mis     = is_d ? d_misalign : 1'b0;
                rdata   = is_d ? d_rdata : if_rdata;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [10];

    int          en_cyc, rdy_cyc, en_cnt, di, ii;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_rd, exp_rd;
    logic        o_we, o_mis;
    logic [AW-1:0] o_addr;
    int          cnt_if_m, cnt_d_m;
    bit          seen_if3;

    int          free_at, exp_if_rdy, exp_d_rdy, dur;
    bit          last_d, if_pend, d_pend, if_srv, d_srv, pick_d_m, exp_d_mis;
    logic [31:0] exp_if_data, exp_d_data;

    initial begin
        vecs[0] = '{1'b1, 2'b00, 32'h23, 32'h000000AB, 4'b1000, 32'hABABABAB, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 32'h21, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
        vecs[2] = '{1'b1, 2'b01, 32'h22, 32'h00001234, 4'b1100, 32'h12341234, 1'b0};
        vecs[3] = '{1'b1, 2'b10, 32'h40, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1'b0, 2'b10, 32'h42, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
        vecs[5] = '{1'b1, 2'b00, 32'h30, 32'hFFFFFF5C, 4'b0001, 32'h5C5C5C5C, 1'b0};
        vecs[6] = '{1'b0, 2'b10, 32'h40, 32'h00000000, 4'b1111, 32'h00000000, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 32'h11, 32'h00007777, 4'b0000, 32'h00000000, 1'b1};
        vecs[8] = '{1'b1, 2'b11, 32'h50, 32'h11223344, 4'b1111, 32'h11223344, 1'b0};
        vecs[9] = '{1'b0, 2'b00, 32'h23, 32'h00000000, 4'b1000, 32'h00000000, 1'b0};

        for (int i = 0; i < 256; i++) begin
            env_mem[i] <= (i == 4) ? 32'h00500093 : init_word(i);
            shadow[i]   = (i == 4) ? 32'h00500093 : init_word(i);
        end

        rst_n = 1'b0; rst3_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        if3_req = 0; if3_addr = 0; d3_req = 0; d3_we = 0; d3_size = 0; d3_addr = 0; d3_wdata = 0;
        tick(); tick();

        // Reset state
        chk("reset_ctl", 32'({mem_en, mem_we, mem_be, mem_addr, if_ready, d_ready, d_misalign}), 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        chk("reset_perf", 32'({perf_if, perf_d}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single fetch, one-cycle memory latency
        run_one(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, en_cyc, rdy_cyc, en_cnt, o_be, o_wd, o_we, o_addr, o_mis, o_rd);
        chk("fetch_en_cycle", 32'(en_cyc), 32'd1);
        chk("fetch_mem_addr", 32'(o_addr), 32'd4);
        chk("fetch_ready_cycle", 32'(rdy_cyc), 32'd3);
        chk("fetch_rdata", o_rd, 32'h00500093);
        $display("fetch addr=0x10 en@%0d ready@%0d rdata=0x%08h", en_cyc, rdy_cyc, o_rd);

        // Simultaneous requests from reset: data first, then fetch; wait counters
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h80;
        di = -1; ii = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (d_ready) begin di = k; d_req = 1'b0; end
            if (if_ready) begin
                ii = k;
                chk("perf_d_at_fetch_ready", 32'(perf_d), PERF ? 32'd3 : 32'd0);
                chk("perf_if_at_fetch_ready", 32'(perf_if), PERF ? 32'd7 : 32'd0);
                if_req = 1'b0;
                break;
            end
        end
        chk("tie_d_ready_cycle", 32'(di), 32'd3);
        chk("tie_if_ready_cycle", 32'(ii), 32'd7);
        $display("tie from reset d_ready@%0d if_ready@%0d", di, ii);
        tick();

        // Sustained requests on both ports: strict alternation D,IF,D,IF,...
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h80;
        cnt_if_m = 0; cnt_d_m = 0;
        for (int k = 0; k <= 24; k++) begin
            chk("alt_d_ready", 32'(d_ready), 32'(k % 8 == 3));
            chk("alt_if_ready", 32'(if_ready), 32'(k % 8 == 7));
            chk("alt_perf_if", 32'(perf_if), PERF ? 32'(cnt_if_m) : 32'd0);
            chk("alt_perf_d", 32'(perf_d), PERF ? 32'(cnt_d_m) : 32'd0);
            if (k % 8 == 3) $display("alternation grant D ready@%0d", k);
            if (k % 8 == 7) $display("alternation grant IF ready@%0d", k);
            if (k % 8 != 7) cnt_if_m = (cnt_if_m < CMAX) ? cnt_if_m + 1 : CMAX;
            if (k % 8 != 3) cnt_d_m  = (cnt_d_m  < CMAX) ? cnt_d_m  + 1 : CMAX;
            if (k < 24) tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Vector table of isolated data accesses
        for (int v = 0; v < 10; v++) begin
            exp_rd = vecs[v].exp_mis ? 32'h0 : shadow[vecs[v].addr[9:2]];
            run_one(1'b1, vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata,
                    en_cyc, rdy_cyc, en_cnt, o_be, o_wd, o_we, o_addr, o_mis, o_rd);
            chk("vec_ready_cycle", 32'(rdy_cyc), vecs[v].exp_mis ? 32'd1 : 32'd3);
            chk("vec_mem_en_count", 32'(en_cnt), vecs[v].exp_mis ? 32'd0 : 32'd1);
            chk("vec_misalign", 32'(o_mis), 32'(vecs[v].exp_mis));
            if (!vecs[v].exp_mis) begin
                chk("vec_en_cycle", 32'(en_cyc), 32'd1);
                chk("vec_be", 32'(o_be), 32'(vecs[v].exp_be));
                chk("vec_wdata", o_wd, vecs[v].exp_wdata);
                chk("vec_we", 32'(o_we), 32'(vecs[v].we));
                chk("vec_addr", 32'(o_addr), 32'(vecs[v].addr[9:2]));
            end
            if (!vecs[v].we || vecs[v].exp_mis) chk("vec_rdata", o_rd, exp_rd);
            if (vecs[v].we && !vecs[v].exp_mis) shadow_store(vecs[v].addr, vecs[v].size, vecs[v].wdata);
            $display("vec %0d we=%0d size=%0d addr=0x%02h be=%b wdata=0x%08h mis=%0d ready@%0d rdata=0x%08h",
                     v, vecs[v].we, vecs[v].size, vecs[v].addr, o_be, o_wd, o_mis, rdy_cyc, o_rd);
        end

        // MEM_LAT=3: reset during WAIT abandons the access, then a full-latency access
        rst3_n = 1'b1; tick();
        if3_req = 1'b1; if3_addr = 32'h24;
        tick();
        chk("lat3_issue_en", 32'(mem3_en), 32'd1);
        tick(); tick();
        rst3_n = 1'b0;
        #1;
        chk("lat3_reset_outputs", 32'({mem3_en, mem3_we, mem3_be, if3_ready, d3_ready, d3_misalign}), 32'h0);
        chk("lat3_reset_rdata", if3_rdata, 32'h0);
        if3_req = 1'b0;
        seen_if3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (if3_ready || mem3_en) seen_if3 = 1'b1;
        end
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (if3_ready || mem3_en) seen_if3 = 1'b1;
        end
        chk("lat3_no_ready_after_reset", 32'(seen_if3), 32'd0);
        d3_req = 1'b1; d3_we = 1'b0; d3_size = 2'b10; d3_addr = 32'h40;
        en_cyc = -1; rdy_cyc = -1; o_rd = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem3_en && en_cyc < 0) en_cyc = k;
            if (d3_ready) begin rdy_cyc = k; o_rd = d3_rdata; break; end
        end
        d3_req = 1'b0;
        chk("lat3_en_cycle", 32'(en_cyc), 32'd1);
        chk("lat3_ready_cycle", 32'(rdy_cyc), 32'd5);
        chk("lat3_rdata", o_rd, {24'hA5A5A5, 8'h10});
        $display("lat3 load addr=0x40 en@%0d ready@%0d rdata=0x%08h", en_cyc, rdy_cyc, o_rd);
        tick();

        // Randomized traffic against a transaction-level timeline model
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        free_at = 0; exp_if_rdy = -1; exp_d_rdy = -1; last_d = 1'b0;
        if_pend = 0; d_pend = 0; if_srv = 0; d_srv = 0; cnt_if_m = 0; cnt_d_m = 0;
        exp_if_data = '0; exp_d_data = '0; exp_d_mis = 1'b0;
        for (int k = 0; k < 600; k++) begin
            chk("rnd_if_ready", 32'(if_ready), 32'(k == exp_if_rdy));
            chk("rnd_d_ready", 32'(d_ready), 32'(k == exp_d_rdy));
            chk("rnd_perf_if", 32'(perf_if), PERF ? 32'(cnt_if_m) : 32'd0);
            chk("rnd_perf_d", 32'(perf_d), PERF ? 32'(cnt_d_m) : 32'd0);
            if (k == exp_if_rdy) begin
                chk("rnd_if_rdata", if_rdata, exp_if_data);
                $display("rnd fetch addr=0x%08h ready@%0d rdata=0x%08h", if_addr, k, if_rdata);
                if_req = 1'b0; if_pend = 0; if_srv = 0;
            end
            if (k == exp_d_rdy) begin
                chk("rnd_d_misalign", 32'(d_misalign), 32'(exp_d_mis));
                if (!d_we || exp_d_mis) chk("rnd_d_rdata", d_rdata, exp_d_data);
                $display("rnd data we=%0d size=%0d addr=0x%08h mis=%0d ready@%0d rdata=0x%08h",
                         d_we, d_size, d_addr, d_misalign, k, d_rdata);
                d_req = 1'b0; d_pend = 0; d_srv = 0;
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_size = 2'($urandom_range(0, 3)); d_addr = $urandom; d_wdata = $urandom;
            end
            if (if_req && k != exp_if_rdy) cnt_if_m = (cnt_if_m < CMAX) ? cnt_if_m + 1 : CMAX;
            if (d_req && k != exp_d_rdy)   cnt_d_m  = (cnt_d_m  < CMAX) ? cnt_d_m  + 1 : CMAX;
            if (k >= free_at && ((if_pend && !if_srv) || (d_pend && !d_srv))) begin
                pick_d_m = (d_pend && !d_srv) && (!(if_pend && !if_srv) || !last_d);
                last_d = pick_d_m;
                if (pick_d_m) begin
                    d_srv = 1;
                    exp_d_mis = is_mis(d_size, d_addr[1:0]);
                    dur = exp_d_mis ? 1 : 2 + LAT1;
                    exp_d_rdy = k + dur;
                    exp_d_data = exp_d_mis ? 32'h0 : shadow[d_addr[9:2]];
                    if (!exp_d_mis && d_we) shadow_store(d_addr, d_size, d_wdata);
                end else begin
                    if_srv = 1;
                    dur = 2 + LAT1;
                    exp_if_rdy = k + dur;
                    exp_if_data = shadow[if_addr[9:2]];
                end
                free_at = k + dur + 1;
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
